// File: rtl/traffic_pkg.sv
// Shared lamp encodings and phase enumeration for the traffic phase sequencer.
package traffic_pkg;

    localparam int unsigned LAMP_W = 3;

    localparam logic [LAMP_W-1:0] LIGHT_OFF    = 3'b000;
    localparam logic [LAMP_W-1:0] LIGHT_RED    = 3'b001;
    localparam logic [LAMP_W-1:0] LIGHT_YELLOW = 3'b010;
    localparam logic [LAMP_W-1:0] LIGHT_GREEN  = 3'b100;

    typedef enum logic [1:0] {
        PH_ALLRED = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10,
        PH_FLASH  = 2'b11
    } phase_t;

endpackage

// File: rtl/rr_dir_arbiter.sv
// Combinational round-robin pick: searches from last+1 wrapping through last inclusive.
module rr_dir_arbiter #(
    parameter int unsigned NUM_DIR = 4,
    parameter int unsigned DIR_W   = $clog2(NUM_DIR)
) (
    input  logic [NUM_DIR-1:0] demand,
    input  logic [DIR_W-1:0]   last,
    output logic               valid,
    output logic [DIR_W-1:0]   next_dir
);

    int unsigned idx;

    // First demanding approach after the last granted one wins.
    always_comb begin
        valid    = 1'b0;
        next_dir = last;
        idx      = 0;
        for (int unsigned i = 1; i <= NUM_DIR; i++) begin
            idx = (32'(last) + i) % NUM_DIR;
            if (!valid && demand[idx]) begin
                valid    = 1'b1;
                next_dir = DIR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Timed multi-approach signal controller: GREEN -> YELLOW -> ALL-RED per approach,
// round-robin among demanding approaches, registered one-hot lamps.
// Optional feature macro: TRAFFIC_FLASH_EN (adds `flash` input and the FLASH phase).
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned NUM_DIR      = 4,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned GREEN_TICKS  = 30,
    parameter int unsigned YELLOW_TICKS = 4,
    parameter int unsigned ALLRED_TICKS = 2,
    localparam int unsigned DIR_W       = $clog2(NUM_DIR)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick_en,
    input  logic                      enable,
    input  logic [NUM_DIR-1:0]        demand,
`ifdef TRAFFIC_FLASH_EN
    input  logic                      flash,
`endif
    output logic [LAMP_W*NUM_DIR-1:0] light,
    output logic [DIR_W-1:0]          active_dir,
    output logic [1:0]                phase,
    output logic                      phase_done
);

    localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;

    // Configuration sanity checks at elaboration.
    if (NUM_DIR < 2) begin : g_bad_num_dir
        $error("traffic_phase_sequencer: NUM_DIR must be >= 2");
    end
    if (GREEN_TICKS < 1 || YELLOW_TICKS < 1 || ALLRED_TICKS < 1) begin : g_bad_ticks
        $error("traffic_phase_sequencer: *_TICKS must be >= 1");
    end
    if (64'(GREEN_TICKS) - 64'd1 >= CNT_SPAN ||
        64'(YELLOW_TICKS) - 64'd1 >= CNT_SPAN ||
        64'(ALLRED_TICKS) - 64'd1 >= CNT_SPAN) begin : g_bad_cnt_w
        $error("traffic_phase_sequencer: CNT_W too narrow for *_TICKS");
    end

    localparam logic [CNT_W-1:0] GREEN_RELOAD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_RELOAD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_RELOAD = CNT_W'(ALLRED_TICKS - 1);

    localparam logic [LAMP_W*NUM_DIR-1:0] ALL_RED    = {NUM_DIR{LIGHT_RED}};
`ifdef TRAFFIC_FLASH_EN
    localparam logic [LAMP_W*NUM_DIR-1:0] ALL_YELLOW = {NUM_DIR{LIGHT_YELLOW}};
    localparam logic [LAMP_W*NUM_DIR-1:0] ALL_OFF    = {NUM_DIR{LIGHT_OFF}};
`endif

    phase_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               arb_valid;
    logic [DIR_W-1:0]   arb_next;
    logic [NUM_DIR-1:0] own_mask;
    logic               other_demand;

    // Lamp word with one approach showing `color` and every other approach red.
    function automatic logic [LAMP_W*NUM_DIR-1:0] lamp_one(
        input logic [DIR_W-1:0]  d,
        input logic [LAMP_W-1:0] color
    );
        logic [LAMP_W*NUM_DIR-1:0] w;
        w = ALL_RED;
        for (int unsigned i = 0; i < NUM_DIR; i++) begin
            if (DIR_W'(i) == d) begin
                w[LAMP_W*i +: LAMP_W] = color;
            end
        end
        return w;
    endfunction

    rr_dir_arbiter #(
        .NUM_DIR (NUM_DIR),
        .DIR_W   (DIR_W)
    ) u_arb (
        .demand   (demand),
        .last     (active_dir),
        .valid    (arb_valid),
        .next_dir (arb_next)
    );

    // Demand from any approach other than the one currently holding green.
    assign own_mask     = NUM_DIR'(1) << active_dir;
    assign other_demand = |(demand & ~own_mask);
    assign phase        = 2'(state);

    // Phase FSM, tick counter, lamp register and exit pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= PH_ALLRED;
            active_dir <= DIR_W'(NUM_DIR - 1);
            cnt        <= ALLRED_RELOAD;
            light      <= ALL_RED;
            phase_done <= 1'b0;
        end else begin
            phase_done <= 1'b0;
`ifdef TRAFFIC_FLASH_EN
            if (flash) begin
                if (state != PH_FLASH) begin
                    state      <= PH_FLASH;
                    light      <= ALL_YELLOW;
                    phase_done <= 1'b1;
                end else if (tick_en) begin
                    light <= (light == ALL_YELLOW) ? ALL_OFF : ALL_YELLOW;
                end
            end else if (state == PH_FLASH) begin
                state      <= PH_ALLRED;
                cnt        <= ALLRED_RELOAD;
                light      <= ALL_RED;
                phase_done <= 1'b1;
            end else
`endif
            if (enable && tick_en) begin
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end else begin
                    phase_done <= 1'b1;
                    case (state)
                        PH_ALLRED: begin
                            if (arb_valid) begin
                                state      <= PH_GREEN;
                                active_dir <= arb_next;
                                cnt        <= GREEN_RELOAD;
                                light      <= lamp_one(arb_next, LIGHT_GREEN);
                            end else begin
                                cnt <= ALLRED_RELOAD;
                            end
                        end
                        PH_GREEN: begin
                            if (other_demand) begin
                                state <= PH_YELLOW;
                                cnt   <= YELLOW_RELOAD;
                                light <= lamp_one(active_dir, LIGHT_YELLOW);
                            end else begin
                                cnt <= GREEN_RELOAD;
                            end
                        end
                        PH_YELLOW: begin
                            state <= PH_ALLRED;
                            cnt   <= ALLRED_RELOAD;
                            light <= ALL_RED;
                        end
                        default: begin
                            state <= PH_ALLRED;
                            cnt   <= ALLRED_RELOAD;
                            light <= ALL_RED;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed self-checking bench for traffic_phase_sequencer
// (NUM_DIR=4, GREEN=5, YELLOW=2, ALLRED=1).
module tb_traffic_phase_sequencer;

    localparam logic [11:0] L_ALLRED = 12'h249;
    localparam logic [11:0] L_G0     = 12'h24C;
    localparam logic [11:0] L_Y0     = 12'h24A;
    localparam logic [11:0] L_G2     = 12'h309;
    localparam logic [11:0] L_Y2     = 12'h289;
    localparam logic [11:0] L_G3     = 12'h849;
    localparam logic [11:0] L_Y3     = 12'h449;

    logic        clk;
    logic        reset;
    logic        tick_en;
    logic        enable;
    logic [3:0]  demand;
    logic        flash;
    logic [11:0] light;
    logic [1:0]  active_dir;
    logic [1:0]  phase;
    logic        phase_done;

    int tests_run;
    int tests_failed;

    traffic_phase_sequencer #(
        .NUM_DIR      (4),
        .CNT_W        (16),
        .GREEN_TICKS  (5),
        .YELLOW_TICKS (2),
        .ALLRED_TICKS (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_en    (tick_en),
        .enable     (enable),
        .demand     (demand),
`ifdef TRAFFIC_FLASH_EN
        .flash      (flash),
`endif
        .light      (light),
        .active_dir (active_dir),
        .phase      (phase),
        .phase_done (phase_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges with the given demand, release just after an edge.
    task automatic do_reset(input logic [3:0] dem);
        reset   = 1'b1;
        tick_en = 1'b1;
        enable  = 1'b1;
        flash   = 1'b0;
        demand  = dem;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        tick_en = 1'b1;
        enable  = 1'b1;
        flash   = 1'b0;
        demand  = 4'b0000;
        #3;
        step();
        tests_run++;
        if ({light, phase, active_dir, phase_done} !== {L_ALLRED, 2'b00, 2'd3, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: got light=%h phase=%b dir=%0d pd=%b, want 249/00/3/0",
                     light, phase, active_dir, phase_done);
        end
    endtask

    task automatic test_single_demand();
        logic pd_exp;
        do_reset(4'b0001);
        for (int c = 1; c <= 20; c++) begin
            step();
            pd_exp = (c == 1) || ((c - 1) % 5 == 0);
            tests_run++;
            if ({light, phase, active_dir, phase_done} !== {L_G0, 2'b01, 2'd0, pd_exp}) begin
                tests_failed++;
                $display("FAIL single_demand c=%0d: got light=%h phase=%b dir=%0d pd=%b, want %h/01/0/%b",
                         c, light, phase, active_dir, phase_done, L_G0, pd_exp);
            end
        end
    endtask

    task automatic test_alternating();
        int          p8;
        int          half;
        logic [11:0] l_exp;
        logic [1:0]  ph_exp;
        logic [1:0]  d_exp;
        logic        pd_exp;
        do_reset(4'b0101);
        for (int c = 1; c <= 24; c++) begin
            step();
            p8   = (c - 1) % 8;
            half = ((c - 1) / 8) % 2;
            d_exp = (half == 1) ? 2'd2 : 2'd0;
            if (p8 < 5) begin
                ph_exp = 2'b01;
                l_exp  = (half == 1) ? L_G2 : L_G0;
            end else if (p8 < 7) begin
                ph_exp = 2'b10;
                l_exp  = (half == 1) ? L_Y2 : L_Y0;
            end else begin
                ph_exp = 2'b00;
                l_exp  = L_ALLRED;
            end
            pd_exp = (p8 == 0) || (p8 == 5) || (p8 == 7);
            tests_run++;
            if ({light, phase, active_dir, phase_done} !== {l_exp, ph_exp, d_exp, pd_exp}) begin
                tests_failed++;
                $display("FAIL alternating c=%0d: got light=%h phase=%b dir=%0d pd=%b, want %h/%b/%0d/%b",
                         c, light, phase, active_dir, phase_done, l_exp, ph_exp, d_exp, pd_exp);
            end
        end
    endtask

    task automatic test_mid_green_demand();
        do_reset(4'b1000);
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 2) demand = 4'b1001;
            if (c == 1 || c == 5) begin
                tests_run++;
                if ({light, phase, active_dir} !== {L_G3, 2'b01, 2'd3}) begin
                    tests_failed++;
                    $display("FAIL mid_green_hold c=%0d: got light=%h phase=%b dir=%0d, want %h/01/3",
                             c, light, phase, active_dir, L_G3);
                end
            end else if (c == 6) begin
                tests_run++;
                if ({light, phase, active_dir} !== {L_Y3, 2'b10, 2'd3}) begin
                    tests_failed++;
                    $display("FAIL mid_green_yellow: got light=%h phase=%b dir=%0d, want %h/10/3",
                             light, phase, active_dir, L_Y3);
                end
            end else if (c == 8) begin
                tests_run++;
                if ({light, phase, active_dir} !== {L_ALLRED, 2'b00, 2'd3}) begin
                    tests_failed++;
                    $display("FAIL mid_green_allred: got light=%h phase=%b dir=%0d, want 249/00/3",
                             light, phase, active_dir);
                end
            end else if (c == 9) begin
                tests_run++;
                if ({light, phase, active_dir} !== {L_G0, 2'b01, 2'd0}) begin
                    tests_failed++;
                    $display("FAIL mid_green_next: got light=%h phase=%b dir=%0d, want %h/01/0",
                             light, phase, active_dir, L_G0);
                end
            end
        end
    endtask

    task automatic test_slow_tick();
        int first_g;
        int first_y;
        first_g = 0;
        first_y = 0;
        do_reset(4'b0101);
        for (int k = 1; k <= 30; k++) begin
            tick_en = (k % 3 == 0);
            step();
            if (first_g == 0 && phase == 2'b01) first_g = k;
            if (first_y == 0 && phase == 2'b10) first_y = k;
        end
        tick_en = 1'b1;
        tests_run++;
        if (first_g !== 3) begin
            tests_failed++;
            $display("FAIL slow_tick_green_start: got cycle %0d, want 3", first_g);
        end
        tests_run++;
        if (first_y - first_g !== 15) begin
            tests_failed++;
            $display("FAIL slow_tick_green_len: got %0d clk, want 15", first_y - first_g);
        end
    endtask

    task automatic test_enable_freeze();
        int ylen;
        do_reset(4'b0101);
        for (int c = 1; c <= 6; c++) step();
        tests_run++;
        if ({light, phase} !== {L_Y0, 2'b10}) begin
            tests_failed++;
            $display("FAIL freeze_enter_yellow: got light=%h phase=%b, want %h/10", light, phase, L_Y0);
        end
        ylen   = 1;
        enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (phase == 2'b10) ylen++;
        end
        tests_run++;
        if ({light, phase, phase_done} !== {L_Y0, 2'b10, 1'b0}) begin
            tests_failed++;
            $display("FAIL freeze_hold: got light=%h phase=%b pd=%b, want %h/10/0",
                     light, phase, phase_done, L_Y0);
        end
        enable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (phase == 2'b10) ylen++;
            else break;
        end
        tests_run++;
        if (ylen !== 6) begin
            tests_failed++;
            $display("FAIL freeze_yellow_len: got %0d clk, want 6", ylen);
        end
        tests_run++;
        if ({light, phase, active_dir, phase_done} !== {L_ALLRED, 2'b00, 2'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL freeze_after: got light=%h phase=%b dir=%0d pd=%b, want 249/00/0/1",
                     light, phase, active_dir, phase_done);
        end
    endtask

    task automatic test_reset_mid_green();
        do_reset(4'b0101);
        for (int c = 1; c <= 3; c++) step();
        tests_run++;
        if (phase !== 2'b01) begin
            tests_failed++;
            $display("FAIL reset_mid_pre: got phase=%b, want 01", phase);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({light, phase, active_dir, phase_done} !== {L_ALLRED, 2'b00, 2'd3, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_mid_green: got light=%h phase=%b dir=%0d pd=%b, want 249/00/3/0",
                     light, phase, active_dir, phase_done);
        end
        step();
        reset = 1'b0;
    endtask

`ifdef TRAFFIC_FLASH_EN
    task automatic test_flash();
        do_reset(4'b0101);
        step();
        step();
        flash = 1'b1;
        step();
        tests_run++;
        if ({light, phase} !== {12'h492, 2'b11}) begin
            tests_failed++;
            $display("FAIL flash_entry: got light=%h phase=%b, want 492/11", light, phase);
        end
        step();
        tests_run++;
        if (light !== 12'h000) begin
            tests_failed++;
            $display("FAIL flash_off: got light=%h, want 000", light);
        end
        step();
        tests_run++;
        if (light !== 12'h492) begin
            tests_failed++;
            $display("FAIL flash_on: got light=%h, want 492", light);
        end
        flash = 1'b0;
        step();
        tests_run++;
        if ({light, phase, active_dir} !== {L_ALLRED, 2'b00, 2'd0}) begin
            tests_failed++;
            $display("FAIL flash_release: got light=%h phase=%b dir=%0d, want 249/00/0",
                     light, phase, active_dir);
        end
        step();
        tests_run++;
        if ({light, phase, active_dir} !== {L_G2, 2'b01, 2'd2}) begin
            tests_failed++;
            $display("FAIL flash_rr_pick: got light=%h phase=%b dir=%0d, want %h/01/2",
                     light, phase, active_dir, L_G2);
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        tick_en      = 1'b1;
        enable       = 1'b1;
        demand       = 4'b0000;
        flash        = 1'b0;
        test_reset();
        test_single_demand();
        test_alternating();
        test_mid_green_demand();
        test_slow_tick();
        test_enable_freeze();
        test_reset_mid_green();
`ifdef TRAFFIC_FLASH_EN
        test_flash();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
